// File: rtl/bram_arb_pkg.sv
// Shared types and default widths for the two-requester BRAM port arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects alternating contested-cycle priority.
package bram_arb_pkg;

   localparam int NUM_COL_DEF    = 4;
   localparam int COL_WIDTH_DEF  = 8;
   localparam int ADDR_WIDTH_DEF = 10;
   localparam int MAX_BURST_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arbState_t;

endpackage

// File: rtl/bram_arb_pick.sv
// Combinational two-way priority pick between requesters r0 and r1.
// prefer1 selects which requester wins when both request.
module bram_arb_pick (
   input  logic req0,
   input  logic req1,
   input  logic prefer1,
   output logic pick0,
   output logic pick1
);

   always_comb begin
      pick0 = 1'b0;
      pick1 = 1'b0;
      if (req0 && req1) begin
         pick0 = ~prefer1;
         pick1 = prefer1;
      end else begin
         pick0 = req0;
         pick1 = req1;
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one no-change byte-write BRAM port between requesters r0 and r1.
// Build option: ARB_ROUND_ROBIN_EN alternates the contested-cycle winner.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_COL    = NUM_COL_DEF,
   parameter int COL_WIDTH  = COL_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int MAX_BURST  = MAX_BURST_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           r0_req,
   input  logic                           r0_lock,
   input  logic [NUM_COL-1:0]             r0_we,
   input  logic [ADDR_WIDTH-1:0]          r0_addr,
   input  logic [NUM_COL*COL_WIDTH-1:0]   r0_wdata,
   output logic                           r0_gnt,
   output logic                           r0_rvalid,
   output logic [NUM_COL*COL_WIDTH-1:0]   r0_rdata,
   input  logic                           r1_req,
   input  logic                           r1_lock,
   input  logic [NUM_COL-1:0]             r1_we,
   input  logic [ADDR_WIDTH-1:0]          r1_addr,
   input  logic [NUM_COL*COL_WIDTH-1:0]   r1_wdata,
   output logic                           r1_gnt,
   output logic                           r1_rvalid,
   output logic [NUM_COL*COL_WIDTH-1:0]   r1_rdata,
   output logic                           ram_en,
   output logic [NUM_COL-1:0]             ram_we,
   output logic [ADDR_WIDTH-1:0]          ram_addr,
   output logic [NUM_COL*COL_WIDTH-1:0]   ram_din,
   input  logic [NUM_COL*COL_WIDTH-1:0]   ram_dout
);

   localparam int DW    = NUM_COL * COL_WIDTH;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arbState_t        state;
   arbState_t        stateNxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNxt;
   logic [CNT_W-1:0] cntInc;
   logic             ptr;
   logic             ptrNxt;
   logic             pick0;
   logic             pick1;
   logic             gnt0;
   logic             gnt1;
   logic             rd0Pend;
   logic             rd1Pend;
   logic [DW-1:0]    hold0;
   logic [DW-1:0]    hold1;

   bram_arb_pick uPick (
      .req0    (r0_req),
      .req1    (r1_req),
      .prefer1 (ptr),
      .pick0   (pick0),
      .pick1   (pick1)
   );

   assign cntInc = cnt + CNT_W'(1);

   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      stateNxt = state;
      cntNxt   = cnt;
      ptrNxt   = ptr;
      unique case (state)
         IDLE: begin
            gnt0 = pick0;
            gnt1 = pick1;
            if (r0_req && r1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
               ptrNxt = pick0;
`else
               ptrNxt = 1'b0;
`endif
            end
            if (MAX_BURST > 1 && gnt0 && r0_lock) begin
               stateNxt = LOCK0;
               cntNxt   = CNT_W'(1);
            end else if (MAX_BURST > 1 && gnt1 && r1_lock) begin
               stateNxt = LOCK1;
               cntNxt   = CNT_W'(1);
            end
         end
         LOCK0: begin
            gnt0 = r0_req;
            if (!r0_req) begin
               stateNxt = IDLE;
               cntNxt   = '0;
            end else if (cntInc == CNT_W'(MAX_BURST)) begin
               // burst exhausted: r1 takes the next contested cycle
               stateNxt = IDLE;
               cntNxt   = '0;
               ptrNxt   = 1'b1;
            end else if (!r0_lock) begin
               stateNxt = IDLE;
               cntNxt   = '0;
            end else begin
               cntNxt = cntInc;
            end
         end
         LOCK1: begin
            gnt1 = r1_req;
            if (!r1_req) begin
               stateNxt = IDLE;
               cntNxt   = '0;
            end else if (cntInc == CNT_W'(MAX_BURST)) begin
               stateNxt = IDLE;
               cntNxt   = '0;
               ptrNxt   = 1'b0;
            end else if (!r1_lock) begin
               stateNxt = IDLE;
               cntNxt   = '0;
            end else begin
               cntNxt = cntInc;
            end
         end
         default: begin
            stateNxt = IDLE;
            cntNxt   = '0;
         end
      endcase
   end

   assign r0_gnt = gnt0 & rst_n;
   assign r1_gnt = gnt1 & rst_n;
   assign ram_en = r0_gnt | r1_gnt;

   always_comb begin
      ram_we   = '0;
      ram_addr = r0_addr;
      ram_din  = r0_wdata;
      if (r1_gnt) begin
         ram_we   = r1_we;
         ram_addr = r1_addr;
         ram_din  = r1_wdata;
      end else if (r0_gnt) begin
         ram_we = r0_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ptr   <= 1'b0;
      end else begin
         state <= stateNxt;
         cnt   <= cntNxt;
         ptr   <= ptrNxt;
      end
   end

   // rdata follows ram_dout in the valid cycle and holds the last read after
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd0Pend <= 1'b0;
         rd1Pend <= 1'b0;
         hold0   <= '0;
         hold1   <= '0;
      end else begin
         rd0Pend <= r0_gnt && (r0_we == '0);
         rd1Pend <= r1_gnt && (r1_we == '0);
         if (rd0Pend) hold0 <= ram_dout;
         if (rd1Pend) hold1 <= ram_dout;
      end
   end

   assign r0_rvalid = rd0Pend;
   assign r1_rvalid = rd1Pend;
   assign r0_rdata  = rd0Pend ? ram_dout : hold0;
   assign r1_rdata  = rd1Pend ? ram_dout : hold1;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a no-change BRAM model.
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_bram_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_req, r0_lock, r1_req, r1_lock;
   logic [3:0]  r0_we, r1_we;
   logic [9:0]  r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata;
   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [31:0] r0_rdata, r1_rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout = 32'h0;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:1023];
   bit          memDone = 1'b0;

   always #5 clk = ~clk;

   bram_port_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .r0_req    (r0_req),
      .r0_lock   (r0_lock),
      .r0_we     (r0_we),
      .r0_addr   (r0_addr),
      .r0_wdata  (r0_wdata),
      .r0_gnt    (r0_gnt),
      .r0_rvalid (r0_rvalid),
      .r0_rdata  (r0_rdata),
      .r1_req    (r1_req),
      .r1_lock   (r1_lock),
      .r1_we     (r1_we),
      .r1_addr   (r1_addr),
      .r1_wdata  (r1_wdata),
      .r1_gnt    (r1_gnt),
      .r1_rvalid (r1_rvalid),
      .r1_rdata  (r1_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   // no-change BRAM: dout only updates on reads
   always @(posedge clk) begin
      if (!memDone) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
         memDone <= 1'b1;
      end else if (ram_en) begin
         if (ram_we == 4'b0000) begin
            ram_dout <= mem[ram_addr];
         end else begin
            for (int b = 0; b < 4; b++)
               if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drv0(input logic req, input logic lock, input logic [3:0] we,
                       input logic [9:0] addr, input logic [31:0] wd);
      r0_req = req; r0_lock = lock; r0_we = we; r0_addr = addr; r0_wdata = wd;
   endtask

   task automatic drv1(input logic req, input logic lock, input logic [3:0] we,
                       input logic [9:0] addr, input logic [31:0] wd);
      r1_req = req; r1_lock = lock; r1_we = we; r1_addr = addr; r1_wdata = wd;
   endtask

   task automatic nextCyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drv0(1'b1, 1'b0, 4'h0, 10'h000, 32'h0);
      drv1(1'b1, 1'b0, 4'h0, 10'h000, 32'h0);

      // reset state, requests present
      @(negedge clk);
      chk("rst_gnt0", {31'd0, r0_gnt}, 32'd0);
      chk("rst_gnt1", {31'd0, r1_gnt}, 32'd0);
      chk("rst_en", {31'd0, ram_en}, 32'd0);
      chk("rst_rv0", {31'd0, r0_rvalid}, 32'd0);
      chk("rst_rdata0", r0_rdata, 32'd0);
      nextCyc();
      rst_n = 1'b1;
      drv1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);

      // r0 partial write then read back
      drv0(1'b1, 1'b0, 4'b0011, 10'h005, 32'hAABBCCDD);
      @(negedge clk);
      chk("wr_gnt0", {31'd0, r0_gnt}, 32'd1);
      chk("wr_gnt1", {31'd0, r1_gnt}, 32'd0);
      chk("wr_en", {31'd0, ram_en}, 32'd1);
      chk("wr_we", {28'd0, ram_we}, 32'h3);
      chk("wr_addr", {22'd0, ram_addr}, 32'h005);
      chk("wr_din", ram_din, 32'hAABBCCDD);
      nextCyc();
      drv0(1'b1, 1'b0, 4'b0000, 10'h005, 32'h0);
      @(negedge clk);
      chk("rd_gnt0", {31'd0, r0_gnt}, 32'd1);
      chk("wr_no_rv0", {31'd0, r0_rvalid}, 32'd0);
      nextCyc();
      drv0(1'b0, 1'b0, 4'b0000, 10'h005, 32'h0);
      @(negedge clk);
      chk("rd_rv0", {31'd0, r0_rvalid}, 32'd1);
      chk("rd_lo16", {16'd0, r0_rdata[15:0]}, 32'h0000CCDD);
      chk("rd_full", r0_rdata, 32'h0000CCDD);
      chk("idle_en", {31'd0, ram_en}, 32'd0);
      chk("idle_we", {28'd0, ram_we}, 32'd0);
      nextCyc();
      @(negedge clk);
      chk("rv0_drop", {31'd0, r0_rvalid}, 32'd0);
      chk("rdata0_hold", r0_rdata, 32'h0000CCDD);
      nextCyc();

      // both read every cycle for 4 cycles
      drv0(1'b1, 1'b0, 4'h0, 10'h005, 32'h0);
      drv1(1'b1, 1'b0, 4'h0, 10'h005, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("cont_gnt0_%0d", k), {31'd0, r0_gnt},
             (RR && (k % 2 == 1)) ? 32'd0 : 32'd1);
         chk($sformatf("cont_gnt1_%0d", k), {31'd0, r1_gnt},
             (RR && (k % 2 == 1)) ? 32'd1 : 32'd0);
         nextCyc();
      end
      drv0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      drv1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      @(negedge clk);
      chk("cont_rv1", {31'd0, r1_rvalid}, RR ? 32'd1 : 32'd0);
      chk("cont_rv0", {31'd0, r0_rvalid}, RR ? 32'd0 : 32'd1);
      chk("cont_rdata0", r0_rdata, 32'h0000CCDD);
      nextCyc();

      // r1 locked burst while r0 waits
      drv1(1'b1, 1'b1, 4'h0, 10'h005, 32'h0);
      @(negedge clk);
      chk("l1_first", {31'd0, r1_gnt}, 32'd1);
      nextCyc();
      drv0(1'b1, 1'b0, 4'h0, 10'h005, 32'h0);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("l1_gnt1_%0d", k), {31'd0, r1_gnt}, 32'd1);
         chk($sformatf("l1_gnt0_%0d", k), {31'd0, r0_gnt}, 32'd0);
         nextCyc();
      end
      @(negedge clk);
      chk("l1_after_gnt0", {31'd0, r0_gnt}, 32'd1);
      chk("l1_after_gnt1", {31'd0, r1_gnt}, 32'd0);
      nextCyc();
      drv0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      drv1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);

      // r0 locked burst while r1 waits; r1 must win afterwards
      drv0(1'b1, 1'b1, 4'h0, 10'h005, 32'h0);
      @(negedge clk);
      chk("l0_first", {31'd0, r0_gnt}, 32'd1);
      nextCyc();
      drv1(1'b1, 1'b0, 4'h0, 10'h005, 32'h0);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("l0_gnt0_%0d", k), {31'd0, r0_gnt}, 32'd1);
         chk($sformatf("l0_gnt1_%0d", k), {31'd0, r1_gnt}, 32'd0);
         nextCyc();
      end
      @(negedge clk);
      chk("l0_after_gnt1", {31'd0, r1_gnt}, 32'd1);
      chk("l0_after_gnt0", {31'd0, r0_gnt}, 32'd0);
      nextCyc();
      drv0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      drv1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      @(negedge clk);
      chk("l0_rdata1", r1_rdata, 32'h0000CCDD);
      nextCyc();

      // lock dropped by req going low: no grant to r1 that cycle
      drv0(1'b1, 1'b1, 4'h0, 10'h005, 32'h0);
      @(negedge clk);
      chk("ld_gnt0", {31'd0, r0_gnt}, 32'd1);
      nextCyc();
      drv0(1'b0, 1'b0, 4'h0, 10'h005, 32'h0);
      drv1(1'b1, 1'b0, 4'h0, 10'h005, 32'h0);
      @(negedge clk);
      chk("ld_blk_gnt1", {31'd0, r1_gnt}, 32'd0);
      chk("ld_blk_en", {31'd0, ram_en}, 32'd0);
      nextCyc();
      @(negedge clk);
      chk("ld_gnt1", {31'd0, r1_gnt}, 32'd1);
      nextCyc();
      drv1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);

      // r1 top-byte write, r0 reads it back next cycle
      drv1(1'b1, 1'b0, 4'b1000, 10'h3FF, 32'h5A223344);
      @(negedge clk);
      chk("ow_gnt1", {31'd0, r1_gnt}, 32'd1);
      chk("ow_we", {28'd0, ram_we}, 32'h8);
      chk("ow_addr", {22'd0, ram_addr}, 32'h3FF);
      nextCyc();
      drv1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      drv0(1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0);
      @(negedge clk);
      chk("ow_gnt0", {31'd0, r0_gnt}, 32'd1);
      chk("ow_rv1_a", {31'd0, r1_rvalid}, 32'd0);
      nextCyc();
      drv0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      @(negedge clk);
      chk("ow_rv0", {31'd0, r0_rvalid}, 32'd1);
      chk("ow_byte3", {24'd0, r0_rdata[31:24]}, 32'h5A);
      chk("ow_full", r0_rdata, 32'h5A000000);
      chk("ow_rv1_b", {31'd0, r1_rvalid}, 32'd0);
      chk("ow_rdata1", r1_rdata, 32'h0000CCDD);
      nextCyc();

      // address wrap: 0x3FF and 0x000 stay independent
      drv0(1'b1, 1'b0, 4'hF, 10'h000, 32'h12345678);
      @(negedge clk);
      chk("wrap_wr", {31'd0, r0_gnt}, 32'd1);
      nextCyc();
      drv0(1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0);
      @(negedge clk);
      chk("wrap_rd_hi", {31'd0, r0_gnt}, 32'd1);
      nextCyc();
      drv0(1'b1, 1'b0, 4'h0, 10'h000, 32'h0);
      @(negedge clk);
      chk("wrap_rv_hi", {31'd0, r0_rvalid}, 32'd1);
      chk("wrap_data_hi", r0_rdata, 32'h5A000000);
      nextCyc();
      drv0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      @(negedge clk);
      chk("wrap_rv_lo", {31'd0, r0_rvalid}, 32'd1);
      chk("wrap_data_lo", r0_rdata, 32'h12345678);
      nextCyc();

      // reset asserted during an r0 locked read grant
      drv0(1'b1, 1'b1, 4'h0, 10'h000, 32'h0);
      @(negedge clk);
      chk("mr_gnt0", {31'd0, r0_gnt}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_gnt0_rst", {31'd0, r0_gnt}, 32'd0);
      chk("mr_en_rst", {31'd0, ram_en}, 32'd0);
      drv0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      nextCyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("mr_rv0", {31'd0, r0_rvalid}, 32'd0);
      chk("mr_rdata0", r0_rdata, 32'd0);
      nextCyc();
      drv0(1'b1, 1'b0, 4'h0, 10'h000, 32'h0);
      drv1(1'b1, 1'b0, 4'h0, 10'h000, 32'h0);
      @(negedge clk);
      chk("mr_cont_gnt0", {31'd0, r0_gnt}, 32'd1);
      chk("mr_cont_gnt1", {31'd0, r1_gnt}, 32'd0);
      nextCyc();
      @(negedge clk);
      chk("mr_next_gnt1", {31'd0, r1_gnt}, RR ? 32'd1 : 32'd0);
      chk("mr_next_rv0", {31'd0, r0_rvalid}, 32'd1);
      chk("mr_next_data0", r0_rdata, 32'h12345678);
      nextCyc();
      drv0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      drv1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
      nextCyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
